// File: rtl/region_shared_read_arbiter.sv
// region_shared_read_arbiter: round-robin, burst-locked sharing of one read region among N readers,
// with a tag pipeline that steers each fixed-latency return beat back to its requester.
module region_shared_read_arbiter #(
  parameter int WIDTH             = 8,
  parameter int LOG2_DEPTH        = 5,
  parameter int NUM_READ_CHANNELS = 3,
  parameter int READ_LATENCY      = 1,
  parameter int MAX_BURST         = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_READ_CHANNELS-1:0]            req_re,
  input  logic [NUM_READ_CHANNELS*LOG2_DEPTH-1:0] req_raddr,
  input  logic [NUM_READ_CHANNELS*2-1:0]          req_rfifobram,
  output logic [NUM_READ_CHANNELS-1:0]            req_grant,
  output logic [NUM_READ_CHANNELS-1:0]            rsp_rvalid,
  output logic [WIDTH-1:0]                        rsp_rdata,
  output logic [NUM_READ_CHANNELS-1:0]            rsp_empty,
  output logic                                    mem_re,
  output logic [LOG2_DEPTH-1:0]                   mem_raddr,
  output logic [1:0]                              mem_rfifobram,
  input  logic                                    mem_rvalid,
  input  logic [WIDTH-1:0]                        mem_rdata,
  input  logic                                    mem_empty
);
  localparam int N  = NUM_READ_CHANNELS;
  localparam int L  = LOG2_DEPTH;
  localparam int RL = READ_LATENCY;
  localparam int CW = $clog2(N);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MB = BW'(MAX_BURST);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_d;
  logic [CW-1:0] rr, owner, owner_d, pick, gid, idx;
  logic [BW-1:0] cnt, cnt_d;
  logic found, keep, others, gv;
  logic [RL:0] tv;
  logic [CW-1:0] tid [0:RL];
  always_comb begin
    pick  = rr;
    found = 1'b0;
    idx   = rr;
    for (int k = 0; k < N; k++) begin
      idx = CW'((int'(rr) + k) % N);
      if (!found && req_re[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end
  // rr already sits just past the owner, so the scan naturally prefers every other channel first
  assign others = |(req_re & ~(N'(1) << owner));
  assign keep   = (state == BURST) && req_re[owner] && ((cnt < MB) || !others);
  always_comb begin
    state_d = state;
    owner_d = owner;
    cnt_d   = cnt;
    gid     = pick;
    gv      = 1'b0;
    if (keep) begin
      gv    = 1'b1;
      gid   = owner;
      cnt_d = (cnt < MB) ? cnt + 1'b1 : cnt;
    end else if (found) begin
      gv      = 1'b1;
      state_d = BURST;
      owner_d = pick;
      cnt_d   = BW'(1);
    end else begin
      state_d = IDLE;
    end
  end
  assign req_grant = (gv && reset) ? N'(1) << gid : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      owner         <= '0;
      cnt           <= '0;
      rr            <= '0;
      mem_re        <= 1'b0;
      mem_raddr     <= '0;
      mem_rfifobram <= '0;
      tv            <= '0;
      for (int i = 0; i <= RL; i++) tid[i] <= '0;
    end else begin
      state  <= state_d;
      owner  <= owner_d;
      cnt    <= cnt_d;
      mem_re <= gv;
      if (gv) begin
        rr            <= (gid == CW'(N - 1)) ? '0 : gid + 1'b1;
        mem_raddr     <= req_raddr[gid*L +: L];
        mem_rfifobram <= req_rfifobram[gid*2 +: 2];
      end
      tv     <= {tv[RL-1:0], gv};
      tid[0] <= gid;
      for (int i = 1; i <= RL; i++) tid[i] <= tid[i-1];
    end
  end
  // untagged returns (e.g. beats from before a reset) are dropped here
  assign rsp_rvalid = (mem_rvalid && tv[RL]) ? N'(1) << tid[RL] : '0;
  assign rsp_rdata  = (mem_rvalid && tv[RL]) ? mem_rdata : '0;
  assign rsp_empty  = {N{mem_empty}};
endmodule

// File: tb/tb_region_shared_read_arbiter.sv
// tb_region_shared_read_arbiter: directed and random traffic against a rule-level arbitration model
// plus a one-cycle-latency region model that returns beats in issue order.
module tb_region_shared_read_arbiter;
  localparam int N = 3, L = 5, W = 8, MB = 4;
  logic clk = 1'b0, reset = 1'b0;
  logic [N-1:0] req_re, req_grant, rsp_rvalid, rsp_empty;
  logic [N*L-1:0] req_raddr;
  logic [N*2-1:0] req_rfifobram;
  logic [W-1:0] rsp_rdata, mem_rdata;
  logic mem_re, mem_rvalid, mem_empty;
  logic [L-1:0] mem_raddr, prev_addr;
  logic [1:0] mem_rfifobram, prev_mode;
  int n_assert = 0, n_fail = 0;
  int owner = -1, cnt = 0, rr = 0, prev_g = -1, fmode = -1;
  int issued[$];
  int olog[$];
  bit stray = 1'b0;
  int exp_pat[16] = '{0,0,0,0,1,1,1,1,2,2,2,2,0,0,0,0};
  always #5 clk = ~clk;
  region_shared_read_arbiter #(.WIDTH(W), .LOG2_DEPTH(L), .NUM_READ_CHANNELS(N),
    .READ_LATENCY(1), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req_re(req_re), .req_raddr(req_raddr),
    .req_rfifobram(req_rfifobram), .req_grant(req_grant), .rsp_rvalid(rsp_rvalid),
    .rsp_rdata(rsp_rdata), .rsp_empty(rsp_empty), .mem_re(mem_re), .mem_raddr(mem_raddr),
    .mem_rfifobram(mem_rfifobram), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_empty(mem_empty));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int model_grant(input logic [N-1:0] r);
    int g = -1;
    int oth = 0;
    for (int i = 0; i < N; i++) if (r[i] && i != owner) oth++;
    if (owner >= 0 && r[owner] && (cnt < MB || oth == 0)) begin
      g = owner;
      if (cnt < MB) cnt++;
    end else begin
      for (int k = 0; k < N; k++) if (g < 0 && r[(rr + k) % N]) g = (rr + k) % N;
      owner = g;
      cnt = (g >= 0) ? 1 : 0;
    end
    if (g >= 0) rr = (g + 1) % N;
    return g;
  endfunction
  task automatic cycle(input logic [N-1:0] newreq, input int addr = -1);
    logic [N-1:0] exp_rv;
    logic [W-1:0] d;
    int g, o;
    chk("mem_re", 32'(mem_re), 32'(prev_g >= 0));
    if (prev_g >= 0) begin
      chk("mem_raddr", 32'(mem_raddr), 32'(prev_addr));
      chk("mem_rfifobram", 32'(mem_rfifobram), 32'(prev_mode));
    end
    exp_rv = '0;
    mem_rvalid = stray;
    d = W'($urandom);
    mem_rdata = d;
    if (issued.size() > 0) begin
      g = issued.pop_front();
      mem_rvalid = 1'b1;
      exp_rv = N'(1) << g;
    end
    if (prev_g >= 0) issued.push_back(prev_g);
    stray = 1'b0;
    for (int i = 0; i < N; i++) if (newreq[i] && !req_re[i]) begin
      req_re[i] = 1'b1;
      req_raddr[i*L +: L] = (addr >= 0) ? L'(addr) : L'($urandom);
      req_rfifobram[i*2 +: 2] = (fmode >= 0) ? 2'(fmode) : 2'($urandom);
    end
    #1;
    g = model_grant(req_re);
    chk("req_grant", 32'(req_grant), (g >= 0) ? 32'(1) << g : 32'(0));
    chk("rsp_rvalid", 32'(rsp_rvalid), 32'(exp_rv));
    if (exp_rv != '0) chk("rsp_rdata", 32'(rsp_rdata), 32'(d));
    chk("rsp_empty", 32'(rsp_empty), 32'({N{mem_empty}}));
    o = -1;
    for (int i = 0; i < N; i++) if (req_grant[i]) o = i;
    olog.push_back(o);
    prev_g = g;
    if (g >= 0) begin
      prev_addr = req_raddr[g*L +: L];
      prev_mode = req_rfifobram[g*2 +: 2];
    end
    @(posedge clk);
    #1;
    if (g >= 0) req_re[g] = 1'b0;
  endtask
  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(req_grant), 0);
    chk({tag, "_rvalid"}, 32'(rsp_rvalid), 0);
    chk({tag, "_rdata"}, 32'(rsp_rdata), 0);
    chk({tag, "_mem_re"}, 32'(mem_re), 0);
    chk({tag, "_raddr"}, 32'(mem_raddr), 0);
    chk({tag, "_mode"}, 32'(mem_rfifobram), 0);
  endtask
  initial begin
    req_re = '1;
    req_raddr = '1;
    req_rfifobram = '1;
    mem_rvalid = 1'b1;
    mem_rdata = '1;
    mem_empty = 1'b0;
    #3;
    check_all_zero("reset");
    req_re = '0;
    mem_rvalid = 1'b0;
    #4;
    reset = 1'b1;
    @(posedge clk);
    #1;
    olog.delete();
    repeat (16) cycle(3'b111);
    for (int i = 0; i < 16; i++) chk("rr_burst_pattern", 32'(olog[i]), 32'(exp_pat[i]));
    repeat (6) cycle(3'b000);
    olog.delete();
    repeat (10) cycle(3'b001);
    for (int i = 0; i < 10; i++) chk("solo_stream", 32'(olog[i]), 0);
    repeat (3) cycle(3'b000);
    olog.delete();
    cycle(3'b010, 5);
    chk("single_grant_ch1", 32'(olog[0]), 1);
    chk("single_addr5", 32'(mem_raddr), 5);
    repeat (3) cycle(3'b000);
    olog.delete();
    cycle(3'b100);
    repeat (5) cycle(3'b101);
    for (int i = 0; i < 4; i++) chk("ch2_burst", 32'(olog[i]), 2);
    chk("ch0_after_ch2", 32'(olog[4]), 0);
    repeat (4) cycle(3'b000);
    mem_empty = 1'b1;
    fmode = 1;
    repeat (6) cycle(3'b011);
    mem_empty = 1'b0;
    fmode = -1;
    repeat (4) cycle(3'b000);
    repeat (300) cycle(N'($urandom));
    repeat (3) cycle(3'b111);
    reset = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 8'hA5;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    check_all_zero("midreset_hold");
    reset = 1'b1;
    req_re = '0;
    mem_rvalid = 1'b0;
    owner = -1;
    cnt = 0;
    rr = 0;
    prev_g = -1;
    issued.delete();
    stray = 1'b1;
    cycle(3'b000);
    cycle(3'b000);
    repeat (200) cycle(N'($urandom));
    repeat (6) cycle(3'b000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
